// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
// The HAZARD_PERF_EN macro enables the performance counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam int PERF_W = 32;

    // Counter increment that holds at all-ones.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_fwd_sel.sv
// Forwarding select for one Execute operand: the M stage wins over W,
// and the excluded register (PC) always reads from the register file.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW        = 4,
    parameter int NOFWD_REG = 15
) (
    input  logic [AW-1:0] ra_e,
    input  logic [AW-1:0] wa_m,
    input  logic [AW-1:0] wa_w,
    input  logic          reg_write_m,
    input  logic          reg_write_w,
    output fwd_sel_t      fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        // int compare so NOFWD_REG = 2**AW can never match
        if (int'(ra_e) != NOFWD_REG) begin
            if (reg_write_m && (ra_e == wa_m)) begin
                fwd_sel = FWD_M;
            end else if (reg_write_w && (ra_e == wa_w)) begin
                fwd_sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the F/D/E/M/W pipeline: forwarding, load-use stall, branch
// flush and multi-cycle memory freeze. HAZARD_PERF_EN adds stall/flush counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int AW        = 4,
    parameter int MEM_LAT   = 3,
    parameter int NOFWD_REG = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     RA1D,
    input  logic [AW-1:0]     RA2D,
    input  logic [AW-1:0]     RA1E,
    input  logic [AW-1:0]     RA2E,
    input  logic [AW-1:0]     WA3E,
    input  logic [AW-1:0]     WA3M,
    input  logic [AW-1:0]     WA3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemReqM,
    input  logic              BranchTakenE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events,
`endif
    output logic              FlushW
);

    localparam bit         MW_EN    = (MEM_LAT > 1);
    localparam logic [3:0] CNT_INIT = 4'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    logic [AW-1:0] ra_e [2];
    fwd_sel_t      fwd_sel [2];

    assign ra_e[0]   = RA1E;
    assign ra_e[1]   = RA2E;
    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_fwd_sel #(
                .AW        (AW),
                .NOFWD_REG (NOFWD_REG)
            ) u_fwd_sel (
                .ra_e        (ra_e[gi]),
                .wa_m        (WA3M),
                .wa_w        (WA3W),
                .reg_write_m (RegWriteM),
                .reg_write_w (RegWriteW),
                .fwd_sel     (fwd_sel[gi])
            );
        end
    endgenerate

    hz_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       memwait;
    logic       ldr;
    logic       branch_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The freeze covers the IDLE trigger cycle plus MEM_LAT-2 WAIT cycles;
    // the WAIT cycle with cnt==0 lets the access leave Memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        memwait = 1'b0;
        case (state_q)
            IDLE: begin
                if (MW_EN && MemReqM) begin
                    memwait = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    memwait = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ldr = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

    // Gating with rst_n drops every stall the moment reset asserts.
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushW       = 1'b0;
        branch_flush = 1'b0;
        if (rst_n) begin
            if (memwait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchTakenE) begin
                FlushD       = 1'b1;
                FlushE       = 1'b1;
                branch_flush = 1'b1;
            end else if (ldr) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (StallF || StallD || StallE || StallM) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end
        if (branch_flush) begin
            flush_events_d = sat_inc(flush_events_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three instances (MEM_LAT 1, 3, 4) share one stimulus
// stream and are compared against an access-age reference model every cycle.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, MemReqM, BranchTakenE;

    logic [1:0] fae [3];
    logic [1:0] fbe [3];
    logic       sf [3], sd [3], se [3], sm [3], fd [3], fe [3], fw [3];
`ifdef HAZARD_PERF_EN
    logic [31:0] sc [3], fc [3];
`endif

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
            hazard_unit_mc #(.AW(4), .MEM_LAT(LAT), .NOFWD_REG(15)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .RA1D         (RA1D),
                .RA2D         (RA2D),
                .RA1E         (RA1E),
                .RA2E         (RA2E),
                .WA3E         (WA3E),
                .WA3M         (WA3M),
                .WA3W         (WA3W),
                .RegWriteM    (RegWriteM),
                .RegWriteW    (RegWriteW),
                .MemtoRegE    (MemtoRegE),
                .MemReqM      (MemReqM),
                .BranchTakenE (BranchTakenE),
                .ForwardAE    (fae[gi]),
                .ForwardBE    (fbe[gi]),
                .StallF       (sf[gi]),
                .StallD       (sd[gi]),
                .StallE       (se[gi]),
                .StallM       (sm[gi]),
                .FlushD       (fd[gi]),
                .FlushE       (fe[gi]),
`ifdef HAZARD_PERF_EN
                .stall_cycles (sc[gi]),
                .flush_events (fc[gi]),
`endif
                .FlushW       (fw[gi])
            );
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each memory access lives lat cycles in Memory,
    // the first lat-1 of which freeze the pipeline.
    int          lat_v [3] = '{1, 3, 4};
    int          age [3];
    int          cur_age [3];
    bit          stall_any [3];
    bit          br_flush [3];
    logic [31:0] m_sc [3], m_fc [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 2'b00;
        if (RegWriteM && ra == WA3M) return 2'b10;
        if (RegWriteW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    task automatic eval_and_check();
        bit mw, br, lu, ldr;
        logic [6:0] exp_ctrl, obs_ctrl;
        ldr = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                age[k]  = -1;
                m_sc[k] = 0;
                m_fc[k] = 0;
            end
            cur_age[k] = (age[k] < 0 && MemReqM && lat_v[k] > 1) ? 0 : age[k];
            mw = rst_n && cur_age[k] >= 0 && cur_age[k] < lat_v[k] - 1;
            br = rst_n && !mw && BranchTakenE;
            lu = rst_n && !mw && !BranchTakenE && ldr;
            stall_any[k] = mw || lu;
            br_flush[k]  = br;
            exp_ctrl = {mw || lu, mw || lu, mw, mw, br, br || lu, mw};
            obs_ctrl = {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k]};
            chk($sformatf("ctrl_lat%0d", lat_v[k]), 32'(obs_ctrl), 32'(exp_ctrl));
            chk($sformatf("fwdA_lat%0d", lat_v[k]), 32'(fae[k]), 32'(ref_fwd(RA1E)));
            chk($sformatf("fwdB_lat%0d", lat_v[k]), 32'(fbe[k]), 32'(ref_fwd(RA2E)));
`ifdef HAZARD_PERF_EN
            chk($sformatf("stall_cycles_lat%0d", lat_v[k]), sc[k], m_sc[k]);
            chk($sformatf("flush_events_lat%0d", lat_v[k]), fc[k], m_fc[k]);
`endif
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked 1 time unit later.
    task automatic tick();
        #1;
        eval_and_check();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                age[k]  = -1;
                m_sc[k] = 0;
                m_fc[k] = 0;
            end else begin
                age[k] = (cur_age[k] >= 0 && cur_age[k] + 1 < lat_v[k]) ? cur_age[k] + 1 : -1;
                if (stall_any[k] && m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
                if (br_flush[k] && m_fc[k] != 32'hFFFF_FFFF) m_fc[k]++;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(2, 5));
    endfunction

    initial begin
        rst_n = 1'b0;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, MemReqM, BranchTakenE} = '0;
        for (int k = 0; k < 3; k++) begin
            age[k] = -1; m_sc[k] = 0; m_fc[k] = 0;
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Forwarding priority and PC exclusion
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        #1 chk("fwdA_M_prio", 32'(fae[0]), 32'h2);
        tick();
        RegWriteM = 1'b0;
        #1 chk("fwdA_W", 32'(fae[0]), 32'h1);
        tick();
        RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15; RegWriteM = 1'b1;
        #1 chk("fwdA_pc_excl", 32'(fae[0]), 32'h0);
        tick();
        RegWriteM = 1'b0; RegWriteW = 1'b0;

        // Load-use for one cycle, then cleared
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #1 chk("ldr_stallF", 32'(sf[0]), 32'h1);
        tick();
        MemtoRegE = 1'b0;
        tick();

        // Branch overrides load-use
        MemtoRegE = 1'b1; BranchTakenE = 1'b1;
        #1 chk("br_over_ldr_stallD", 32'(sd[0]), 32'h0);
        tick();
        MemtoRegE = 1'b0; BranchTakenE = 1'b0;
        tick();

        // Single access held through the freeze, then back-to-back accesses
        MemReqM = 1'b1;
        repeat (3) tick();
        MemReqM = 1'b0;
        tick();
        MemReqM = 1'b1;
        repeat (6) tick();
        MemReqM = 1'b0;
        tick();

        // Branch deferred while memory waits
        MemReqM = 1'b1; BranchTakenE = 1'b1;
        repeat (4) tick();
        MemReqM = 1'b0; BranchTakenE = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a MEM_LAT=4 wait
        MemReqM = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        #1 chk("rst_midwait_stallM", 32'(sm[2]), 32'h0);
        tick();
        rst_n = 1'b1; MemReqM = 1'b0;
        repeat (2) tick();

        // Randomised traffic
        repeat (400) begin
            RA1D = rand_reg(); RA2D = rand_reg(); RA1E = rand_reg(); RA2E = rand_reg();
            WA3E = rand_reg(); WA3M = rand_reg(); WA3W = rand_reg();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = ($urandom_range(0, 2) == 0);
            MemReqM      = ($urandom_range(0, 2) == 0);
            BranchTakenE = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the single-cycle pipeline hazard unit for the Filter-GPU 5-stage pipeline (F/D/E/M/W).
- Keeps the M/W operand forwarding and the load-use stall.
- Adds taken-branch flush, multi-cycle data-memory wait (FSM plus counter) with a whole-pipeline freeze, and configurable register-address width.
- Sits beside the datapath; all stall/flush/forward selects originate here.

Parameters:
- AW, 4, register address width (number of registers = 2**AW)
- MEM_LAT, 3, data-memory access latency in cycles; legal range 1..16
- NOFWD_REG, 15, register index never forwarded (PC); set to 2**AW to disable the exclusion

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- RA1D, RA2D  in  AW  source registers in Decode
- RA1E, RA2E  in  AW  source registers in Execute
- WA3E, WA3M, WA3W  in  AW  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  write enables in M/W
- MemtoRegE  in  1  load in Execute
- MemReqM  in  1  load/store occupying Memory
- BranchTakenE  in  1  taken branch resolved in Execute
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold stage registers
- FlushD, FlushE, FlushW  out  1  insert bubble into stage register

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, cnt=0.
  - All Stall*/Flush* = 0 during and after reset until a hazard occurs.
  - Forward* follow inputs combinationally; they are not registered.
- Forwarding (combinational, per operand):
  - M match with RegWriteM → 10.
  - Else W match with RegWriteW → 01.
  - Else 00.
  - M has priority over W.
  - Any RAxE == NOFWD_REG → 00.
- Load-use: ldr = MemtoRegE && (RA1D==WA3E || RA2D==WA3E) → StallF, StallD, FlushE.
- Branch: BranchTakenE → FlushD, FlushE. Overrides ldr: StallF=StallD=0, because the D instruction is wrong-path.
- Memory wait FSM (states IDLE, WAIT); cnt is 4 bits:
  - MEM_LAT==1: FSM stays in IDLE permanently; memwait=0.
  - IDLE, MemReqM=1 and MEM_LAT>1: memwait=1 this cycle; cnt←MEM_LAT-2; →WAIT.
  - WAIT, cnt≠0: memwait=1; cnt←cnt-1.
  - WAIT, cnt==0: memwait=0; →IDLE. The memory instruction advances at this edge, and a new MemReqM in the next IDLE cycle retriggers the wait.
  - Total freeze per access: exactly MEM_LAT-1 cycles.
- memwait=1 effects:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0. Branch and ldr effects are deferred: evaluated again once memwait drops, since their inputs are held.
- Priority: memwait > BranchTakenE > ldr.
- Reset mid-WAIT: FSM returns to IDLE immediately and every stall drops asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments each cycle any Stall* is 1.
  - flush_events increments each cycle FlushE is 1 because of BranchTakenE.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - hz_state_t enum: IDLE, WAIT.
  - Constant PERF_W=32.
- Sub-module hazard_fwd_sel (one operand's comparison and priority, parameter AW), instantiated twice, for A and B.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Same with RegWriteM=0 → 01. RA1E=15 → 00.
- MemtoRegE=1, WA3E=5, RA2D=5, MEM_LAT=1 → StallF=StallD=FlushE=1 for exactly 1 cycle, then all 0.
- Same load-use plus BranchTakenE=1 → FlushD=FlushE=1, StallF=StallD=0.
- MEM_LAT=3, MemReqM pulse held by freeze → Stall*, FlushW high for exactly 2 cycles. Back-to-back accesses → 2 low-stall gap of 1 cycle, then 2 more.
- MemReqM with BranchTakenE=1 during WAIT → FlushD/FlushE=0 until the cycle memwait drops, then 1.
- rst_n low in the middle of WAIT (MEM_LAT=4) → all stalls 0 immediately. After release, FSM=IDLE, no residual stall. With HAZARD_PERF_EN, counters read 0.
